// File: rtl/regfile_wb_sink.sv
// Register-file write sink: 32x32 GPR bank cleared by a post-reset sweep, plus a
// small resettable system bank. Define WB_BYPASS_EN for write-first read forwarding.
module regfile_wb_sink #(
  parameter int          SYS_AW      = 3,
  parameter logic [31:0] SYS_RST_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegW_en,
  input  logic              RegW_en_System,
  input  logic [4:0]        RegD,
  input  logic [31:0]       WriteData,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [SYS_AW-1:0] sys_ra,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  output logic [31:0]       sys_rd,
  output logic              ready
);

  localparam int NUM_SYS = 2 ** SYS_AW;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q;
  logic [4:0]        idx_q;
  logic [4:0]        idx_d;
  logic              ready_q;
  logic [31:0]       gpr_q [32];
  logic [31:0]       sys_q [NUM_SYS];

  logic              gpr_we;
  logic              sys_we;
  logic [SYS_AW-1:0] sys_wa;

  // Writes commit only in RUN and never on a reset edge; r0 is never stored.
  assign sys_wa = RegD[SYS_AW-1:0];
  assign gpr_we = RegW_en && (RegD != 5'd0) && (state_q == RUN) && !reset;
  assign sys_we = RegW_en_System && (state_q == RUN) && !reset;
  assign idx_d  = idx_q + 5'd1;
  assign ready  = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= 5'd0;
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_SYS; i++) begin
        sys_q[i] <= SYS_RST_VAL;
      end
    end else begin
      case (state_q)
        CLEAR: begin
          gpr_q[idx_q] <= 32'h0;
          idx_q        <= idx_d;
          if (idx_q == 5'd31) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (gpr_we) begin
            gpr_q[RegD] <= WriteData;
          end
          if (sys_we) begin
            sys_q[sys_wa] <= WriteData;
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= 5'd0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // GPR reads are forced to zero during the sweep since the array is not yet cleared.
  always_comb begin
    rd1 = 32'h0;
    rd2 = 32'h0;
    if (state_q == RUN && ra1 != 5'd0) begin
      rd1 = gpr_q[ra1];
    end
    if (state_q == RUN && ra2 != 5'd0) begin
      rd2 = gpr_q[ra2];
    end
`ifdef WB_BYPASS_EN
    if (gpr_we && RegD == ra1) begin
      rd1 = WriteData;
    end
    if (gpr_we && RegD == ra2) begin
      rd2 = WriteData;
    end
`endif
  end

  always_comb begin
    sys_rd = sys_q[sys_ra];
`ifdef WB_BYPASS_EN
    if (sys_we && sys_wa == sys_ra) begin
      sys_rd = WriteData;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: a behavioural model is checked every
// negedge, plus literal expectations at the points of interest.
module tb_regfile_wb_sink;

  localparam logic [31:0] SYS_RST_VAL = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        RegW_en;
  logic        RegW_en_System;
  logic [4:0]  RegD;
  logic [31:0] WriteData;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [2:0]  sys_ra;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] sys_rd;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_sink dut (
    .clk            (clk),
    .reset          (reset),
    .RegW_en        (RegW_en),
    .RegW_en_System (RegW_en_System),
    .RegD           (RegD),
    .WriteData      (WriteData),
    .ra1            (ra1),
    .ra2            (ra2),
    .sys_ra         (sys_ra),
    .rd1            (rd1),
    .rd2            (rd2),
    .sys_rd         (sys_rd),
    .ready          (ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: cycles since reset release decide readiness
  logic [31:0] gpr_m [32];
  logic [31:0] sys_m [8];
  int          since_rst = 0;
  logic        model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      since_rst <= 0;
      model_ok  <= 1'b1;
      for (int i = 0; i < 8; i++) sys_m[i] <= SYS_RST_VAL;
    end else if (since_rst < 32) begin
      gpr_m[since_rst] <= 32'h0;
      since_rst        <= since_rst + 1;
    end else begin
      if (RegW_en && RegD != 5'd0) gpr_m[RegD] <= WriteData;
      if (RegW_en_System) sys_m[RegD % 8] <= WriteData;
    end
  end

  function automatic logic [31:0] exp_gpr(input logic [4:0] ra);
    logic [31:0] v;
    v = 32'h0;
    if (since_rst >= 32 && ra != 5'd0) v = gpr_m[ra];
`ifdef WB_BYPASS_EN
    if (since_rst >= 32 && RegW_en && RegD != 5'd0 && RegD == ra) v = WriteData;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_sys(input logic [2:0] ra);
    logic [31:0] v;
    v = sys_m[ra];
`ifdef WB_BYPASS_EN
    if (since_rst >= 32 && RegW_en_System && (RegD % 8) == ra) v = WriteData;
`endif
    return v;
  endfunction

  // scoreboard compare, every negedge once the model is defined
  always @(negedge clk) begin
    if (model_ok && !reset) begin
      n_cmp += 4;
      if (ready !== (since_rst >= 32)) begin
        n_bad++;
        $display("FAIL model_ready t=%0t got=%0b exp=%0b", $time, ready, since_rst >= 32);
      end
      if (rd1 !== exp_gpr(ra1)) begin
        n_bad++;
        $display("FAIL model_rd1 t=%0t ra1=%0d got=%h exp=%h", $time, ra1, rd1, exp_gpr(ra1));
      end
      if (rd2 !== exp_gpr(ra2)) begin
        n_bad++;
        $display("FAIL model_rd2 t=%0t ra2=%0d got=%h exp=%h", $time, ra2, rd2, exp_gpr(ra2));
      end
      if (sys_rd !== exp_sys(sys_ra)) begin
        n_bad++;
        $display("FAIL model_sys t=%0t sys_ra=%0d got=%h exp=%h", $time, sys_ra, sys_rd, exp_sys(sys_ra));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegW_en        = 1'b0;
    RegW_en_System = 1'b0;
    RegD           = 5'd0;
    WriteData      = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // 32 sweep edges after reset release; optional write pulse presented before edge 5
  task automatic sweep(input logic poke);
    for (int e = 1; e <= 32; e++) begin
      if (poke && e == 5) begin
        RegW_en = 1'b1; RegW_en_System = 1'b1; RegD = 5'd3; WriteData = 32'h1;
      end else begin
        idle();
      end
      sys_ra = 3'(e % 8);
      step();
      chk("sweep_rd1_zero", rd1, 32'h0);
      chk("sweep_sys_rst", sys_rd, SYS_RST_VAL);
      if (e == 31) chk("ready_low_edge31", {31'h0, ready}, 32'h0);
      if (e == 32) chk("ready_high_edge32", {31'h0, ready}, 32'h1);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra1 = 5'd5; ra2 = 5'd0; sys_ra = 3'd0;

    // 1: reset two cycles then release and sweep; 5: write pulse during CLEAR
    step();
    step();
    chk("reset_ready", {31'h0, ready}, 32'h0);
    reset = 1'b0;
    sweep(1'b1);
    ra1 = 5'd3; sys_ra = 3'd3; #1;
    chk("clear_write_ignored_gpr", rd1, 32'h0);
    chk("clear_write_ignored_sys", sys_rd, SYS_RST_VAL);

    // 2: r0 write discarded, system write to index 7
    RegW_en = 1'b1; RegD = 5'd0; WriteData = 32'hDEAD_BEEF;
    step();
    idle(); ra1 = 5'd0; #1;
    chk("r0_reads_zero", rd1, 32'h0);
    RegW_en_System = 1'b1; RegD = 5'd7; WriteData = 32'h1234_5678;
    step();
    idle(); sys_ra = 3'd7; #1;
    chk("sys7_write", sys_rd, 32'h1234_5678);

    // 3: same-cycle read of r9
    ra1 = 5'd9; ra2 = 5'd9;
    RegW_en = 1'b1; RegD = 5'd9; WriteData = 32'hA5A5_A5A5; #1;
`ifdef WB_BYPASS_EN
    chk("r9_same_cycle_rd1", rd1, 32'hA5A5_A5A5);
    chk("r9_same_cycle_rd2", rd2, 32'hA5A5_A5A5);
`else
    chk("r9_same_cycle_rd1", rd1, 32'h0);
    chk("r9_same_cycle_rd2", rd2, 32'h0);
`endif
    step();
    idle(); #1;
    chk("r9_next_rd1", rd1, 32'hA5A5_A5A5);
    chk("r9_next_rd2", rd2, 32'hA5A5_A5A5);

    // 4: dual enable with upper RegD bits masked for the system bank
    RegW_en = 1'b1; RegW_en_System = 1'b1; RegD = 5'd10; WriteData = 32'h0000_00FF;
    step();
    idle(); ra1 = 5'd10; sys_ra = 3'd2; #1;
    chk("dual_gpr10", rd1, 32'h0000_00FF);
    chk("dual_sys2", sys_rd, 32'h0000_00FF);
    ra2 = 5'd2; #1;
    chk("dual_gpr2_untouched", rd2, 32'h0);

    // 6: reset mid-RUN with a write presented on the reset edge
    RegW_en = 1'b1; RegD = 5'd4; WriteData = 32'h55;
    step();
    RegW_en = 1'b0; RegW_en_System = 1'b1; RegD = 5'd1; WriteData = 32'h66;
    step();
    idle(); ra1 = 5'd4; sys_ra = 3'd1; #1;
    chk("pre_reset_r4", rd1, 32'h55);
    chk("pre_reset_sys1", sys_rd, 32'h66);
    reset = 1'b1;
    RegW_en = 1'b1; RegW_en_System = 1'b1; RegD = 5'd1; WriteData = 32'h77;
    step();
    chk("reset_edge_ready", {31'h0, ready}, 32'h0);
    chk("reset_edge_sys1", sys_rd, SYS_RST_VAL);
    reset = 1'b0;
    sweep(1'b0);
    ra1 = 5'd4; sys_ra = 3'd1; #1;
    chk("post_sweep_r4", rd1, 32'h0);
    chk("post_sweep_sys1", sys_rd, SYS_RST_VAL);

    // a few varied writes checked by the model on the following cycles
    for (int k = 1; k < 8; k++) begin
      RegW_en = 1'b1; RegW_en_System = 1'(k % 2);
      RegD = 5'(k * 5); WriteData = 32'h1000_0000 + 32'(k * 17);
      ra1 = 5'(k * 5); ra2 = 5'((k - 1) * 5); sys_ra = 3'(k * 5);
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
